// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory slave.
// Request channel uses valid/ready; read data returns on a separate rvalid strobe.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access at a time.
// Optional build macro LSU_MISALIGN_CHECK_EN: when defined, misaligned
// halfword/word accesses return rsp_err without a bus cycle; when undefined,
// the low address bits below the access size are ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// ISSUE  | mem_valid held with stable command until mem_ready
// WAIT_R | load issued, waiting for mem_rvalid
// RESP   | one-cycle rsp_valid pulse back to writeback
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_loadCtrl,
  input  logic [1:0]        req_storeCtrl,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t      state;
  logic [2:0]  ld_ctrl;
  logic [1:0]  ld_off;

  logic [1:0]  acc_size;
  logic        illegal;
  logic        misalign;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign req_ready = (state == IDLE);

  // Access size is 00 byte, 01 half, 10 word for both load and store encodings.
  assign acc_size = req_we ? req_storeCtrl : req_loadCtrl[1:0];

  // Request decode: legality, alignment, byte lanes and replicated store data.
  always_comb begin
    illegal  = req_we ? (req_storeCtrl == 2'b11)
                      : ((req_loadCtrl[1:0] == 2'b11) || (req_loadCtrl[2:1] == 2'b11));
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = ((acc_size == 2'b01) && req_addr[0]) ||
               ((acc_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    be_n    = 4'b1111;
    wdata_n = req_wdata;
    if (req_we) begin
      case (req_storeCtrl)
        2'b00: begin
          be_n    = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  // Load extract from the returned word using the captured funct3 and offset.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = mem.mem_rdata[7:0];
      2'd1:    ld_byte = mem.mem_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (ld_ctrl)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_result = {24'h0, ld_byte};
      3'b101:  ld_result = {16'h0, ld_half};
      default: ld_result = mem.mem_rdata;
    endcase
  end

  // Sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ld_ctrl       <= 3'b000;
      ld_off        <= 2'b00;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= 32'h0;
      mem.mem_valid <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ld_ctrl <= req_loadCtrl;
            ld_off  <= req_addr[1:0];
            if (illegal || misalign) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              mem.mem_valid <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem.mem_be    <= be_n;
              mem.mem_wdata <= wdata_n;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem.mem_ready) begin
            mem.mem_valid <= 1'b0;
            if (mem.mem_we) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem.mem_rvalid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ld_result;
            state     <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
